// File: rtl/cpu_ctrl_pkg.sv
// Shared control-word definitions for the 8-bit bus CPU sequencer.
// Purely constants; no logic, no latency, no flow control.
package cpu_ctrl_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int CW_HLT = 15;
    localparam int CW_MI  = 14;
    localparam int CW_RI  = 13;
    localparam int CW_RO  = 12;
    localparam int CW_IO  = 11;
    localparam int CW_II  = 10;
    localparam int CW_AI  = 9;
    localparam int CW_AO  = 8;
    localparam int CW_EO  = 7;
    localparam int CW_SU  = 6;
    localparam int CW_BI  = 5;
    localparam int CW_OI  = 4;
    localparam int CW_CE  = 3;
    localparam int CW_CO  = 2;
    localparam int CW_J   = 1;
    localparam int CW_FI  = 0;

    // Active-high masks; the control word itself is the inverse of their OR.
    localparam logic [15:0] M_HLT = 16'd1 << CW_HLT;
    localparam logic [15:0] M_MI  = 16'd1 << CW_MI;
    localparam logic [15:0] M_RI  = 16'd1 << CW_RI;
    localparam logic [15:0] M_RO  = 16'd1 << CW_RO;
    localparam logic [15:0] M_IO  = 16'd1 << CW_IO;
    localparam logic [15:0] M_II  = 16'd1 << CW_II;
    localparam logic [15:0] M_AI  = 16'd1 << CW_AI;
    localparam logic [15:0] M_AO  = 16'd1 << CW_AO;
    localparam logic [15:0] M_EO  = 16'd1 << CW_EO;
    localparam logic [15:0] M_SU  = 16'd1 << CW_SU;
    localparam logic [15:0] M_BI  = 16'd1 << CW_BI;
    localparam logic [15:0] M_OI  = 16'd1 << CW_OI;
    localparam logic [15:0] M_CE  = 16'd1 << CW_CE;
    localparam logic [15:0] M_CO  = 16'd1 << CW_CO;
    localparam logic [15:0] M_J   = 16'd1 << CW_J;
    localparam logic [15:0] M_FI  = 16'd1 << CW_FI;

    localparam logic [15:0] CW_IDLE     = 16'hFFFF;
    localparam logic [15:0] CW_FETCH_T0 = ~(M_CO | M_MI);
    localparam logic [15:0] CW_FETCH_T1 = ~(M_RO | M_II | M_CE);
    localparam logic [15:0] CW_HLT_WORD = ~M_HLT;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode decode: (opcode, step, flags) -> active-low word + last-step flag.
// Zero latency, no flow control. Conditional jumps honour flags only with COND_JUMP_EN.
module microcode_rom
    import cpu_ctrl_pkg::*;
#(
    parameter int MAX_STEP = 4
) (
    input  logic [3:0]  opcode,
    input  logic [2:0]  step,
    input  logic        flag_c,
    input  logic        flag_z,
    output logic [15:0] ctrl_word,
    output logic        last_step
);

    logic jc_ok;
    logic jz_ok;

`ifdef COND_JUMP_EN
    assign jc_ok = flag_c;
    assign jz_ok = flag_z;
`else
    logic unused_flags;
    assign unused_flags = flag_c ^ flag_z;
    assign jc_ok = 1'b0;
    assign jz_ok = 1'b0;
`endif

    function automatic logic [15:0] decode(input logic [3:0] op, input logic [2:0] s,
                                           input logic jc, input logic jz);
        logic [15:0] m;
        m = 16'd0;
        case (s)
            3'd0: m = M_CO | M_MI;
            3'd1: m = M_RO | M_II | M_CE;
            3'd2: begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: m = M_IO | M_MI;
                    OP_LDI:  m = M_IO | M_AI;
                    OP_JMP:  m = M_IO | M_J;
                    OP_JC:   m = jc ? (M_IO | M_J) : 16'd0;
                    OP_JZ:   m = jz ? (M_IO | M_J) : 16'd0;
                    OP_OUT:  m = M_AO | M_OI;
                    OP_HLT:  m = M_HLT;
                    default: m = 16'd0;
                endcase
            end
            3'd3: begin
                case (op)
                    OP_LDA:         m = M_RO | M_AI;
                    OP_ADD, OP_SUB: m = M_RO | M_BI;
                    OP_STA:         m = M_AO | M_RI;
                    default:        m = 16'd0;
                endcase
            end
            3'd4: begin
                case (op)
                    OP_ADD:  m = M_EO | M_AI | M_FI;
                    OP_SUB:  m = M_EO | M_AI | M_SU | M_FI;
                    default: m = 16'd0;
                endcase
            end
            default: m = 16'd0;
        endcase
        return ~m;
    endfunction

    logic [15:0] next_word;

    always_comb begin
        ctrl_word = CW_IDLE;
        next_word = CW_IDLE;
        if (step <= 3'(MAX_STEP)) begin
            ctrl_word = decode(opcode, step, jc_ok, jz_ok);
        end
        if (step < 3'(MAX_STEP)) begin
            next_word = decode(opcode, step + 3'd1, jc_ok, jz_ok);
        end
        // An empty next word is skipped, so the counter wraps early.
        last_step = (step >= 3'(MAX_STEP)) || (next_word == CW_IDLE);
    end

endmodule

// File: rtl/control_sequencer.sv
// Microstep counter (falling-edge), halt latch and clear forcing around microcode_rom.
// ctrl_n is combinational from step; clr aborts immediately. Optional macro: COND_JUMP_EN.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MAX_STEP = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  opcode,
    input  logic        flag_c,
    input  logic        flag_z,
    output logic [15:0] ctrl_n,
    output logic [2:0]  step,
    output logic        halted
);

    logic [2:0]  step_q;
    logic [2:0]  step_d;
    logic        halted_q;
    logic [15:0] rom_word;
    logic        rom_last;
    logic        hlt_now;

    microcode_rom #(
        .MAX_STEP (MAX_STEP)
    ) u_rom (
        .opcode    (opcode),
        .step      (step_q),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .ctrl_word (rom_word),
        .last_step (rom_last)
    );

    assign hlt_now = ~rom_word[CW_HLT];

    always_comb begin
        step_d = step_q + 3'd1;
        if (halted_q || hlt_now) begin
            step_d = step_q;
        end else if (rom_last) begin
            step_d = 3'd0;
        end
    end

    // Falling-edge update gives the word half a period to settle before loads.
    always_ff @(negedge clk or posedge clr) begin
        if (clr) begin
            step_q   <= 3'd0;
            halted_q <= 1'b0;
        end else begin
            step_q <= step_d;
            if (hlt_now) begin
                halted_q <= 1'b1;
            end
        end
    end

    assign ctrl_n = clr      ? CW_IDLE     :
                    halted_q ? CW_HLT_WORD : rom_word;
    assign step   = step_q;
    assign halted = ~clr & (halted_q | hlt_now);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboarded random-instruction bench for control_sequencer against a table-driven model.
module tb_control_sequencer;

    localparam logic [15:0] B_HLT = 16'h8000, B_MI = 16'h4000, B_RI = 16'h2000, B_RO = 16'h1000;
    localparam logic [15:0] B_IO  = 16'h0800, B_II = 16'h0400, B_AI = 16'h0200, B_AO = 16'h0100;
    localparam logic [15:0] B_EO  = 16'h0080, B_SU = 16'h0040, B_BI = 16'h0020, B_OI = 16'h0010;
    localparam logic [15:0] B_CE  = 16'h0008, B_CO = 16'h0004, B_J  = 16'h0002, B_FI = 16'h0001;
    localparam logic [15:0] DRIVERS = B_RO | B_IO | B_AO | B_EO | B_CO;

    typedef struct packed {
        logic [2:0]  st;
        logic [15:0] w;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr;
    logic [3:0]  opcode;
    logic        flag_c;
    logic        flag_z;
    logic [15:0] ctrl_n;
    logic [2:0]  step;
    logic        halted;

    int   n_vec = 0;
    int   n_err = 0;
    logic check_en = 1'b0;
    exp_t exp_q[$];

    control_sequencer #(.MAX_STEP(4)) dut (
        .clk    (clk),
        .clr    (clr),
        .opcode (opcode),
        .flag_c (flag_c),
        .flag_z (flag_z),
        .ctrl_n (ctrl_n),
        .step   (step),
        .halted (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: list of asserted signals per cycle, straight from the instruction table.
    task automatic model(input logic [3:0] op, input logic fc, input logic fz, output int len);
        logic [15:0] m[$];
        logic        jc, jz;
        exp_t        e;
`ifdef COND_JUMP_EN
        jc = fc;
        jz = fz;
`else
        jc = 1'b0;
        jz = 1'b0;
`endif
        m.push_back(B_CO | B_MI);
        m.push_back(B_RO | B_II | B_CE);
        case (op)
            4'h1: begin m.push_back(B_IO | B_MI); m.push_back(B_RO | B_AI); end
            4'h2: begin m.push_back(B_IO | B_MI); m.push_back(B_RO | B_BI); m.push_back(B_EO | B_AI | B_FI); end
            4'h3: begin m.push_back(B_IO | B_MI); m.push_back(B_RO | B_BI); m.push_back(B_EO | B_AI | B_SU | B_FI); end
            4'h4: begin m.push_back(B_IO | B_MI); m.push_back(B_AO | B_RI); end
            4'h5: m.push_back(B_IO | B_AI);
            4'h6: m.push_back(B_IO | B_J);
            4'h7: if (jc) m.push_back(B_IO | B_J);
            4'h8: if (jz) m.push_back(B_IO | B_J);
            4'hE: m.push_back(B_AO | B_OI);
            default: ;
        endcase
        len = m.size();
        for (int i = 0; i < len; i++) begin
            e.st = 3'(i);
            e.w  = ~m[i];
            exp_q.push_back(e);
        end
    endtask

    // Monitor: one sample per rising edge, mid-step.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (check_en) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow_step", {13'd0, step}, 16'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_step", {13'd0, step}, {13'd0, e.st});
                    check("sb_ctrl_n", ctrl_n, e.w);
                    check("sb_halted", {15'd0, halted}, 16'd0);
                    check("sb_one_driver", {15'd0, ($countones(~ctrl_n & DRIVERS) <= 1)}, 16'd1);
                end
            end
        end
    end

    initial begin
        int len;
        logic [3:0] op;
        clr    = 1'b1;
        opcode = 4'h0;
        flag_c = 1'b0;
        flag_z = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_step", {13'd0, step}, 16'd0);
        check("reset_halted", {15'd0, halted}, 16'd0);
        check("reset_ctrl_n", ctrl_n, 16'hFFFF);

        @(negedge clk);
        #1 clr = 1'b0;
        #1 check("release_t0_word", ctrl_n, 16'hBFFB);
        check_en = 1'b1;

        // Sweep every non-halting opcode, then random instruction stream.
        for (int n = 0; n < 95; n++) begin
            op = (n < 15) ? 4'(n) : 4'($urandom_range(0, 14));
            opcode = op;
            flag_c = 1'($urandom_range(0, 1));
            flag_z = 1'($urandom_range(0, 1));
            model(op, flag_c, flag_z, len);
            repeat (len) @(negedge clk);
            #1;
        end
        check_en = 1'b0;
        check("sb_drained", 16'(exp_q.size()), 16'd0);

        // Clear in the middle of ADD T3.
        opcode = 4'h2;
        repeat (3) @(negedge clk);
        #1;
        check("add_t3_step", {13'd0, step}, 16'd3);
        check("add_t3_ctrl_n", ctrl_n, ~(B_RO | B_BI));
        clr = 1'b1;
        #1;
        check("midclr_ctrl_n", ctrl_n, 16'hFFFF);
        check("midclr_step", {13'd0, step}, 16'd0);
        check("midclr_halted", {15'd0, halted}, 16'd0);
        @(negedge clk);
        #1 clr = 1'b0;
        #1 check("midclr_release_word", ctrl_n, 16'hBFFB);

        // HLT: freeze at T2 until clr.
        opcode = 4'hF;
        flag_c = 1'($urandom_range(0, 1));
        flag_z = 1'($urandom_range(0, 1));
        repeat (2) @(negedge clk);
        #1;
        check("hlt_t2_step", {13'd0, step}, 16'd2);
        check("hlt_t2_ctrl_n", ctrl_n, 16'h7FFF);
        check("hlt_t2_halted", {15'd0, halted}, 16'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            check("hlt_hold_step", {13'd0, step}, 16'd2);
            check("hlt_hold_ctrl_n", ctrl_n, 16'h7FFF);
            check("hlt_hold_halted", {15'd0, halted}, 16'd1);
        end
        clr = 1'b1;
        #1;
        check("hlt_clr_halted", {15'd0, halted}, 16'd0);
        check("hlt_clr_step", {13'd0, step}, 16'd0);
        check("hlt_clr_ctrl_n", ctrl_n, 16'hFFFF);
        opcode = 4'h0;
        @(negedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        #1 check("post_hlt_t1_step", {13'd0, step}, 16'd1);
        check("post_hlt_halted", {15'd0, halted}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
